// File: rtl/cr_debounce_if.sv
// cr_debounce_if: groups the debouncer's level input, qualification tick and outputs.
//   D        - synchronized level input          (master -> slave)
//   SampleEn - qualification tick                (master -> slave)
//   Q        - debounced level                   (slave -> master)
//   Rise     - one-cycle pulse on a Q 0->1 change (slave -> master)
//   Fall     - one-cycle pulse on a Q 1->0 change (slave -> master)
//   Busy     - qualification in progress          (slave -> master)
interface cr_debounce_if;
   logic D;
   logic SampleEn;
   logic Q;
   logic Rise;
   logic Fall;
   logic Busy;
   modport master (output D, SampleEn, input Q, Rise, Fall, Busy);
   modport slave  (input D, SampleEn, output Q, Rise, Fall, Busy);
endinterface

// File: rtl/cr_debounce.sv
// cr_debounce: Q follows D only after pStableCycles consecutive qualifying samples of D!=Q.
//   Clk   - clock, rising edge
//   Rst_n - asynchronous active-low reset (Q=pInitLevel, pulses and count cleared)
//   bus   - cr_debounce_if.slave: D, SampleEn in; Q, Rise, Fall, Busy out (all registered state)
module cr_debounce #(
   parameter int pStableCycles = 16,
   parameter bit pInitLevel    = 1'b0
) (
   input logic            Clk,
   input logic            Rst_n,
   cr_debounce_if.slave   bus
);
   localparam int CW = (pStableCycles > 1) ? $clog2(pStableCycles) : 1;
   localparam logic [CW-1:0] LAST = CW'(pStableCycles - 1);

   typedef enum logic {STABLE, QUALIFY} state_t;

   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_q, w_q_nxt;
   logic          r_rise, w_rise_nxt;
   logic          r_fall, w_fall_nxt;
   logic          w_diff, w_load;
   state_t        w_state;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_cnt  <= '0;
         r_q    <= pInitLevel;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_q    <= w_q_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   // Any agreeing sample restarts the count; a gated-off sample freezes it.
   always_comb begin
      w_diff     = bus.D ^ r_q;
      w_load     = w_diff & bus.SampleEn & (r_cnt == LAST);
      w_cnt_nxt  = !w_diff ? '0 : !bus.SampleEn ? r_cnt : w_load ? '0 : r_cnt + CW'(1);
      w_q_nxt    = w_load ? bus.D : r_q;
      w_rise_nxt = w_load & bus.D;
      w_fall_nxt = w_load & ~bus.D;
   end

   always_comb begin
      w_state  = (r_cnt != '0) ? QUALIFY : STABLE;
      bus.Q    = r_q;
      bus.Rise = r_rise;
      bus.Fall = r_fall;
      bus.Busy = (w_state == QUALIFY);
   end
endmodule
